// File: rtl/math_expression_inverse.sv
// math_expression_inverse
//   Recovers d from the forward expression q = ((3c+1)(a-b) - 4d) >>> 1, rmd = numerator LSB:
//     d = ((3c+1)(a-b) - (2q+rmd)) >>> 2
//   The product is formed by a W+1 step radix-2 shift-add multiplier on magnitudes, then the
//   sign is applied, the forward numerator is subtracted and the result is shifted down by two.
//   Latency is W+3 edges from the accepting edge to the edge that raises valid.
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high reset
//   start  in   request, accepted only when idle
//   a,b,c  in   W-bit signed forward operands
//   q      in   2W+4-bit signed forward quotient
//   rmd    in   forward remainder bit
//   busy   out  high while an operation is in flight
//   valid  out  one-cycle done pulse
//   d      out  W-bit signed recovered operand
//   exact  out  recovered numerator divisible by 4
//   ovf    out  true d outside the signed W-bit range
//
// Configuration
//   MATH_INV_OVF_EN  when defined, ovf reports range overflow of d; otherwise ovf is tied to 0.

module math_expression_inverse #(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    input  logic signed [W-1:0]   c,
    input  logic signed [2*W+3:0] q,
    input  logic                  rmd,
    output logic                  busy,
    output logic                  valid,
    output logic signed [W-1:0]   d,
    output logic                  exact,
    output logic                  ovf
);

    localparam int CW = $clog2(W + 1) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, MUL, SUB} state_t;

    state_t                  state;
    logic signed [W-1:0]     a_q, b_q, c_q;
    logic signed [2*W+3:0]   q_q;
    logic                    rmd_q;
    logic        [2*W+2:0]   mcand;
    logic        [W:0]       mplier;
    logic                    neg;
    logic        [2*W+2:0]   acc;
    logic        [CW-1:0]    cnt;

    // Operand preparation for LOAD
    logic signed [W+1:0]     c_ext, m1;
    logic signed [W:0]       m2;
    logic        [W+1:0]     mag1;
    logic        [W:0]       mag2;

    always_comb begin
        c_ext = {{2{c_q[W-1]}}, c_q};
        m1    = c_ext + c_ext + c_ext + (W+2)'(1);
        m2    = {a_q[W-1], a_q} - {b_q[W-1], b_q};
        mag1  = m1[W+1] ? -m1 : m1;
        mag2  = m2[W]   ? -m2 : m2;
    end

    // Final combine for SUB: 2q+rmd is exactly q with rmd appended below it
    logic signed [2*W+5:0]   p_mag, p_s, n_s, diff;

    always_comb begin
        p_mag = {3'b000, acc};
        p_s   = neg ? -p_mag : p_mag;
        n_s   = {q_q[2*W+3], q_q, rmd_q};
        diff  = p_s - n_s;
    end

`ifdef MATH_INV_OVF_EN
    // diff >>> 2 fits W signed bits iff diff[2W+5:W+1] are all copies of the sign
    logic ovf_c;
    logic ovf_q;
    always_comb begin
        ovf_c = !((&diff[2*W+5:W+1]) || !(|diff[2*W+5:W+1]));
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            q_q    <= '0;
            rmd_q  <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            d      <= '0;
            exact  <= 1'b0;
`ifdef MATH_INV_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        c_q   <= c;
                        q_q   <= q;
                        rmd_q <= rmd;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    mcand  <= {{(W+1){1'b0}}, mag1};
                    mplier <= mag2;
                    neg    <= m1[W+1] ^ m2[W];
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= MUL;
                end
                MUL: begin
                    // LSB-first: multiplicand shifts up as multiplier bits shift out
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(W)) begin
                        state <= SUB;
                    end
                end
                SUB: begin
                    d     <= diff[W+1:2];
                    exact <= (diff[1:0] == 2'b00);
`ifdef MATH_INV_OVF_EN
                    ovf_q <= ovf_c;
`endif
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_math_expression_inverse.sv
module tb_math_expression_inverse;

    localparam int W = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic signed [W-1:0]   a, b, c;
    logic signed [2*W+3:0] q;
    logic                  rmd;
    logic                  busy, valid, exact, ovf;
    logic signed [W-1:0]   d;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    math_expression_inverse #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .q     (q),
        .rmd   (rmd),
        .busy  (busy),
        .valid (valid),
        .d     (d),
        .exact (exact),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide signed arithmetic straight from the inverse formula
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic [W-1:0] mc, input logic [2*W+3:0] mq,
                                  input logic mr, output logic [W-1:0] md,
                                  output logic me, output logic mo);
        logic signed [2*W+5:0] aa, bb, cc, qq, rr, diff, sh, lo, hi;
        aa   = $signed(ma);
        bb   = $signed(mb);
        cc   = $signed(mc);
        qq   = $signed(mq);
        rr   = 0;
        rr[0] = mr;
        diff = (3 * cc + 1) * (aa - bb) - (2 * qq + rr);
        sh   = diff >>> 2;
        md   = sh[W-1:0];
        me   = (sh * 4 == diff);
        lo   = 1;
        lo   = lo <<< (W - 1);
        hi   = lo - 1;
        lo   = -lo;
`ifdef MATH_INV_OVF_EN
        mo   = (sh < lo) || (sh > hi);
`else
        mo   = 1'b0;
`endif
    endfunction

    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tc,
                         input logic [2*W+3:0] tq, input logic tr);
        a   = ta;
        b   = tb_;
        c   = tc;
        q   = tq;
        rmd = tr;
    endtask

    // Waits (bounded) for valid; lat = edges since t0, or -1 on timeout
    task automatic wait_valid(input int t0, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int k = 0; k < W + 10; k++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                if (valid) begin
                    seen = 1'b1;
                    lat  = cyc - t0;
                end
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [W-1:0] tc, input logic [2*W+3:0] tq, input logic tr,
                          input logic [W-1:0] ed, input logic ee, input logic eo);
        int t0, lat;
        @(posedge clk);
        #1;
        drive(ta, tb_, tc, tq, tr);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        chk({tag, ":busy_run"}, busy, 1'b1);
        wait_valid(t0, lat);
        chk({tag, ":latency"}, lat, W + 3);
        chk({tag, ":d"}, d, ed);
        chk({tag, ":exact"}, exact, ee);
        chk({tag, ":ovf"}, ovf, eo);
        chk({tag, ":busy_done"}, busy, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, ":valid_pulse"}, valid, 1'b0);
        chk({tag, ":d_hold"}, d, ed);
    endtask

    initial begin
        logic [W-1:0]          ed, ra, rb, rc, dt;
        logic                  ee, eo, rr;
        logic [2*W+3:0]        rq;
        logic signed [2*W+5:0] num, sa, sb, sc, sd;
        int                    t0, lat, npulse;

        reset = 1'b1;
        start = 1'b0;
        drive('0, '0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst:busy", busy, 1'b0);
        chk("rst:valid", valid, 1'b0);
        chk("rst:d", d, 32'h0);
        chk("rst:exact", exact, 1'b0);
        chk("rst:ovf", ovf, 1'b0);
        reset = 1'b0;

        // Directed vectors
        run_op("v1", 32'd5, 32'd2, 32'd1, 68'd0, 1'b0, 32'd3, 1'b1, 1'b0);
        run_op("v2", 32'd7, 32'd1, 32'd2, 68'd23, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("v3", 32'd7, 32'd1, 32'd2, 68'd23, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        model(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 68'd0, 1'b0, ed, ee, eo);
`ifdef MATH_INV_OVF_EN
        chk("v4:model_ovf", eo, 1'b1);
`endif
        run_op("v4", 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 68'd0, 1'b0, ed, ee, eo);

        // Random vectors: forward-encode a known d, sometimes corrupt rmd
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                ra = W'($urandom_range(200)) - W'(100);
                rb = W'($urandom_range(200)) - W'(100);
                rc = W'($urandom_range(200)) - W'(100);
            end else begin
                ra = $urandom;
                rb = $urandom;
                rc = $urandom;
            end
            dt  = $urandom;
            sa  = $signed(ra);
            sb  = $signed(rb);
            sc  = $signed(rc);
            sd  = $signed(dt);
            num = (3 * sc + 1) * (sa - sb) - 4 * sd;
            rq  = num[2*W+4:1];
            rr  = num[0];
            if (i % 3 == 2) begin
                rr = ~rr;
                model(ra, rb, rc, rq, rr, ed, ee, eo);
                run_op("rnd_inexact", ra, rb, rc, rq, rr, ed, ee, eo);
            end else begin
                run_op("rnd_exact", ra, rb, rc, rq, rr, dt, 1'b1, 1'b0);
            end
        end

        // Start while busy is ignored; start in the valid cycle is accepted
        @(posedge clk);
        #1;
        drive(32'd5, 32'd2, 32'd1, 68'd0, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        drive(32'd100, 32'd3, 32'd9, 68'd77, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drive('0, '0, '0, '0, 1'b0);
        wait_valid(t0, lat);
        chk("b2b:lat1", lat, W + 3);
        chk("b2b:d1", d, 32'd3);
        chk("b2b:exact1", exact, 1'b1);
        drive(32'd7, 32'd1, 32'd2, 68'd23, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        chk("b2b:busy2", busy, 1'b1);
        wait_valid(t0, lat);
        chk("b2b:lat2", lat, W + 3);
        chk("b2b:d2", d, 32'hFFFF_FFFE);
        chk("b2b:exact2", exact, 1'b0);

        // Reset mid-operation abandons it
        @(posedge clk);
        #1;
        drive(32'd7, 32'd1, 32'd2, 68'd23, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rstmid:busy", busy, 1'b0);
        chk("rstmid:valid", valid, 1'b0);
        chk("rstmid:d", d, 32'h0);
        chk("rstmid:exact", exact, 1'b0);
        chk("rstmid:ovf", ovf, 1'b0);
        npulse = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (valid) npulse++;
        end
        chk("rstmid:no_valid", npulse, 0);

        // Reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start:busy", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_start:busy_after", busy, 1'b0);

        // Operation after reset still works
        run_op("post_rst", 32'd5, 32'd2, 32'd1, 68'd0, 1'b0, 32'd3, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
